droute_cfg_sequencer: RTL and testbench

- Command-driven scheduler for the data_route switch fabric.
- Buffers switch-configuration commands, each carrying three 19-bit switch words plus an input-enable mask.
- Applies one command at a time to data_route: drives the switch words and in_valid, then counts per-switch beat pulses (count_switch_N_tvalid) until every switch reaches its programmed beat count.
- Reports each completion on a done stream, then advances to the next command.

---
 rtl/droute_cfg_sequencer.sv | 152 +++++++++++++++
 tb/tb_droute_cfg_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/droute_cfg_sequencer.sv
// Queues data_route switch configurations and applies them one at a time, counting beats per switch until each hits its target.
// in_valid rises two edges after a push into an empty FIFO; s_cmd_tready is a registered !full; the done beat holds until m_done_tready.
module droute_cfg_sequencer #(
    parameter int DEPTH = 4,
    parameter int SW_W  = 19,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      s_cmd_tdata,
    input  logic             s_cmd_tvalid,
    output logic             s_cmd_tready,
    input  logic             abort,
    output logic [SW_W-1:0]  droute_switch_0,
    output logic [SW_W-1:0]  droute_switch_1,
    output logic [SW_W-1:0]  droute_switch_2,
    input  logic             count_switch_0_tvalid,
    input  logic             count_switch_1_tvalid,
    input  logic             count_switch_2_tvalid,
    output logic [5:0]       in_valid,
    output logic [7:0]       m_done_tdata,
    output logic             m_done_tvalid,
    input  logic             m_done_tready,
    output logic             m_done_tlast,
    output logic             busy,
    output logic             err
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int MSK_LO = 3 * SW_W;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef logic [PTR_W:0] fcnt_t;

    state_t            state_q, state_d;
    logic [63:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    fcnt_t             count_q, count_d;
    logic              push, pop;
    logic [63:0]       head;
    logic [CNT_W-1:0]  cnt_q [3];
    logic [CNT_W-1:0]  cnt_d [3];
    logic [CNT_W-1:0]  tgt [3];
    logic [2:0]        pulse;
    logic [5:0]        mask_q, mask_d;
    logic              last_q;
    logic              pulse_err, all_done;
    logic [7:0]        seq_q;

    assign head   = mem[rd_ptr_q];
    assign tgt[0] = droute_switch_0[CNT_W-1:0];
    assign tgt[1] = droute_switch_1[CNT_W-1:0];
    assign tgt[2] = droute_switch_2[CNT_W-1:0];
    assign pulse  = {count_switch_2_tvalid, count_switch_1_tvalid, count_switch_0_tvalid};
    assign mask_d = pop ? head[MSK_LO+5:MSK_LO] : mask_q;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        push      = s_cmd_tvalid && s_cmd_tready && !abort;
        pulse_err = 1'b0;
        all_done  = 1'b1;
        count_d   = count_q;
        for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i];

        unique case (state_q)
            IDLE: if (count_q != '0) state_d = LOAD;
            LOAD: begin
                pop = 1'b1;
                for (int i = 0; i < 3; i++) cnt_d[i] = '0;
                state_d = RUN;
            end
            RUN: begin
                // A pulse beyond the target is a protocol error and is not counted.
                for (int i = 0; i < 3; i++) begin
                    if (pulse[i]) begin
                        if (cnt_q[i] < tgt[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        else pulse_err = 1'b1;
                    end
                    if (cnt_d[i] != tgt[i]) all_done = 1'b0;
                end
                if (all_done) state_d = DONE;
            end
            DONE: if (m_done_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != RUN && pulse != '0) pulse_err = 1'b1;

        if (push && !pop)      count_d = count_q + fcnt_t'(1);
        else if (pop && !push) count_d = count_q - fcnt_t'(1);

        if (abort) begin
            state_d = IDLE;
            pop     = 1'b0;
            count_d = '0;
            for (int i = 0; i < 3; i++) cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= s_cmd_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            s_cmd_tready    <= 1'b1;
            busy            <= 1'b0;
            err             <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            droute_switch_0 <= '0;
            droute_switch_1 <= '0;
            droute_switch_2 <= '0;
            mask_q          <= '0;
            last_q          <= 1'b0;
            in_valid        <= '0;
            m_done_tvalid   <= 1'b0;
            m_done_tdata    <= '0;
            m_done_tlast    <= 1'b0;
            seq_q           <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            s_cmd_tready <= (count_d != fcnt_t'(DEPTH));
            busy         <= (state_d != IDLE) || (count_d != '0);
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            if (pulse_err && !abort) err <= 1'b1;
            if (pop) begin
                droute_switch_0 <= head[SW_W-1:0];
                droute_switch_1 <= head[2*SW_W-1:SW_W];
                droute_switch_2 <= head[3*SW_W-1:2*SW_W];
                mask_q          <= mask_d;
                last_q          <= head[MSK_LO+6];
            end
            in_valid      <= (state_d == RUN) ? mask_d : '0;
            m_done_tvalid <= (state_d == DONE);
            m_done_tdata  <= (state_d == DONE) ? seq_q : '0;
            m_done_tlast  <= (state_d == DONE) && last_q;
            if (state_q == DONE && m_done_tready && !abort) seq_q <= seq_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_droute_cfg_sequencer.sv
// Directed bench for droute_cfg_sequencer: scoreboard of expected completions, auto beat-pulse generator.
module tb_droute_cfg_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_cmd_tdata;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic        abort;
    logic [18:0] droute_switch_0, droute_switch_1, droute_switch_2;
    logic        count_switch_0_tvalid, count_switch_1_tvalid, count_switch_2_tvalid;
    logic [5:0]  in_valid;
    logic [7:0]  m_done_tdata;
    logic        m_done_tvalid;
    logic        m_done_tready;
    logic        m_done_tlast;
    logic        busy;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  sb_q [$];
    logic [47:0] tgt_q [$];
    int          rem [3];
    int          extra [3];
    logic [2:0]  pls;
    logic [5:0]  prev_iv;
    int          run_cyc;
    logic [7:0]  push_seq, comp_seq;

    always #5 clk = ~clk;

    droute_cfg_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
        .abort(abort),
        .droute_switch_0(droute_switch_0), .droute_switch_1(droute_switch_1), .droute_switch_2(droute_switch_2),
        .count_switch_0_tvalid(count_switch_0_tvalid), .count_switch_1_tvalid(count_switch_1_tvalid),
        .count_switch_2_tvalid(count_switch_2_tvalid),
        .in_valid(in_valid),
        .m_done_tdata(m_done_tdata), .m_done_tvalid(m_done_tvalid), .m_done_tready(m_done_tready),
        .m_done_tlast(m_done_tlast), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive beat pulses, score any done handshake, then advance to 1 time unit past the edge.
    task automatic tick();
        logic [47:0] t;
        logic [8:0]  e;
        if (in_valid != 6'd0 && prev_iv == 6'd0 && tgt_q.size() > 0) begin
            t = tgt_q.pop_front();
            rem[0] = int'(t[15:0]);
            rem[1] = int'(t[31:16]);
            rem[2] = int'(t[47:32]);
            run_cyc = 0;
        end
        if (in_valid != 6'd0) run_cyc++;
        for (int i = 0; i < 3; i++) pls[i] = (in_valid != 6'd0) && (rem[i] > 0 || extra[i] > 0);
        {count_switch_2_tvalid, count_switch_1_tvalid, count_switch_0_tvalid} = pls;
        if (m_done_tvalid && m_done_tready) begin
            chk("done_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("done_tdata", 64'(m_done_tdata), 64'(e[7:0]));
                chk("done_tlast", 64'(m_done_tlast), 64'(e[8]));
                comp_seq++;
            end
        end
        prev_iv = in_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pls[i]) begin
                if (rem[i] > 0) rem[i]--;
                else extra[i]--;
            end
        end
    endtask

    task automatic send_cmd(input logic [18:0] w0, input logic [18:0] w1, input logic [18:0] w2,
                            input logic [5:0] mask, input logic last);
        int n;
        n = 0;
        s_cmd_tdata  = {last, mask, w2, w1, w0};
        s_cmd_tvalid = 1'b1;
        while (s_cmd_tready !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk("cmd_accept_timeout", 64'(n < 500), 64'd1);
        sb_q.push_back({last, push_seq});
        push_seq++;
        tgt_q.push_back({w2[15:0], w1[15:0], w0[15:0]});
        tick();
        s_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_vld(input int budget);
        int n;
        n = 0;
        while (m_done_tvalid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_done_vld", 64'(m_done_tvalid), 64'd1);
    endtask

    task automatic wait_iv(input int budget);
        int n;
        n = 0;
        while (in_valid == 6'd0 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_in_valid", 64'(in_valid != 6'd0), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic clear_model();
        sb_q.delete();
        tgt_q.delete();
        for (int i = 0; i < 3; i++) begin
            rem[i]   = 0;
            extra[i] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; s_cmd_tdata = '0; s_cmd_tvalid = 1'b0; abort = 1'b0; m_done_tready = 1'b0;
        count_switch_0_tvalid = 1'b0; count_switch_1_tvalid = 1'b0; count_switch_2_tvalid = 1'b0;
        push_seq = 8'd0; comp_seq = 8'd0; run_cyc = 0; prev_iv = 6'd0;
        clear_model();
        repeat (3) tick();
        chk("rst_tready", 64'(s_cmd_tready), 64'd1);
        chk("rst_in_valid", 64'(in_valid), 64'd0);
        chk("rst_done_vld", 64'(m_done_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_sw0", 64'(droute_switch_0), 64'd0);
        rst_n = 1'b1;
        tick();

        // 145/138/131-beat command
        m_done_tready = 1'b1;
        send_cmd(19'h10091, 19'h1008A, 19'h10083, 6'h3F, 1'b1);
        wait_iv(10);
        chk("t1_sw0", 64'(droute_switch_0), 64'h10091);
        chk("t1_sw1", 64'(droute_switch_1), 64'h1008A);
        chk("t1_sw2", 64'(droute_switch_2), 64'h10083);
        chk("t1_in_valid", 64'(in_valid), 64'h3F);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_vld(300);
        chk("t1_run_cycles", 64'(run_cyc), 64'd145);
        chk("t1_in_valid_off", 64'(in_valid), 64'd0);
        chk("t1_seq", 64'(m_done_tdata), 64'd0);
        drain(10);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // zero targets, done stalled, FIFO fills behind it
        m_done_tready = 1'b0;
        send_cmd(19'd0, 19'd0, 19'd0, 6'h05, 1'b0);
        wait_iv(10);
        chk("t3_in_valid", 64'(in_valid), 64'h05);
        tick();
        chk("t3_in_valid_1cyc", 64'(in_valid), 64'd0);
        chk("t3_done_vld", 64'(m_done_tvalid), 64'd1);
        chk("t3_done_tdata", 64'(m_done_tdata), 64'd1);
        for (int i = 0; i < 4; i++) send_cmd(19'(3 + i), 19'd0, 19'd0, 6'h01, 1'b0);
        chk("t2_tready_full", 64'(s_cmd_tready), 64'd0);
        s_cmd_tdata  = {1'b1, 6'h01, 19'd0, 19'd0, 19'd7};
        s_cmd_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_stall_vld", 64'(m_done_tvalid), 64'd1);
            chk("t3_stall_tdata", 64'(m_done_tdata), 64'd1);
            chk("t3_stall_in_valid", 64'(in_valid), 64'd0);
            chk("t2_stall_tready", 64'(s_cmd_tready), 64'd0);
        end
        m_done_tready = 1'b1;
        send_cmd(19'd7, 19'd0, 19'd0, 6'h01, 1'b1);
        drain(200);
        chk("t2_err", 64'(err), 64'd0);

        // over-target pulses on switch 0
        extra[0] = 3;
        send_cmd(19'd4, 19'd0, 19'd20, 6'h3F, 1'b0);
        wait_vld(100);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_run_cycles", 64'(run_cyc), 64'd20);
        chk("t4_seq", 64'(m_done_tdata), 64'd7);
        drain(10);

        // abort mid-run with two queued commands
        send_cmd(19'h10091, 19'h1008A, 19'h10083, 6'h3F, 1'b0);
        send_cmd(19'd1, 19'd0, 19'd0, 6'h01, 1'b0);
        send_cmd(19'd2, 19'd0, 19'd0, 6'h01, 1'b1);
        n = 0;
        while (rem[0] != 95 && n < 300) begin
            tick();
            n++;
        end
        chk("t5_reach_pulse50", 64'(rem[0]), 64'd95);
        abort        = 1'b1;
        s_cmd_tdata  = {1'b0, 6'h01, 19'd0, 19'd0, 19'd9};
        s_cmd_tvalid = 1'b1;
        tick();
        abort        = 1'b0;
        s_cmd_tvalid = 1'b0;
        clear_model();
        push_seq = comp_seq;
        chk("t5_in_valid", 64'(in_valid), 64'd0);
        chk("t5_done_vld", 64'(m_done_tvalid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_tready", 64'(s_cmd_tready), 64'd1);
        chk("t5_err_kept", 64'(err), 64'd1);
        repeat (5) begin
            tick();
            chk("t5_no_done", 64'(m_done_tvalid), 64'd0);
            chk("t5_flushed", 64'(busy), 64'd0);
        end
        send_cmd(19'd0, 19'd0, 19'd0, 6'h02, 1'b1);
        wait_vld(20);
        chk("t5_seq_unchanged", 64'(m_done_tdata), 64'd8);
        drain(10);

        // reset while a done is stalled
        m_done_tready = 1'b0;
        send_cmd(19'd0, 19'd0, 19'd0, 6'h01, 1'b1);
        send_cmd(19'd5, 19'd0, 19'd0, 6'h01, 1'b0);
        wait_vld(20);
        rst_n = 1'b0;
        tick();
        chk("t6_tready", 64'(s_cmd_tready), 64'd1);
        chk("t6_in_valid", 64'(in_valid), 64'd0);
        chk("t6_done_vld", 64'(m_done_tvalid), 64'd0);
        chk("t6_done_tdata", 64'(m_done_tdata), 64'd0);
        chk("t6_done_tlast", 64'(m_done_tlast), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        chk("t6_sw0", 64'(droute_switch_0), 64'd0);
        rst_n = 1'b1;
        clear_model();
        push_seq = 8'd0;
        comp_seq = 8'd0;
        m_done_tready = 1'b1;
        tick();
        send_cmd(19'd0, 19'd0, 19'd0, 6'h04, 1'b0);
        wait_vld(20);
        chk("t6_seq_after_reset", 64'(m_done_tdata), 64'd0);
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
